// File: rtl/seven_stage_solo_instr_sequencer_pkg.sv
// Shared types for the solo-instruction sequencer of the privileged seven-stage core.
// Holds the sequencer FSM state encodings.
package seven_stage_solo_instr_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SOLO  = 2'd2
    } solo_state_e;

endpackage

// File: rtl/seven_stage_inflight_counter.sv
// Saturating up/down count of instructions between decode and retire; clr wins.
// One-cycle update; simultaneous inc/dec holds, dec at zero is dropped, inc at max saturates.
module seven_stage_inflight_counter #(
    parameter int CNT_W        = 3,
    parameter int INFLIGHT_MAX = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(INFLIGHT_MAX);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d  = count_q;
        overflow = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (inc && !dec) begin
            if (count_q == MAX_VAL) begin
                overflow = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seven_stage_solo_instr_sequencer.sv
// Serialises solo instructions: drains older work, issues the solo op alone,
// then flushes younger work until it retires. Hazard is a pure state decode.
module seven_stage_solo_instr_sequencer
    import seven_stage_solo_instr_sequencer_pkg::*;
#(
    parameter int CORE            = 0,
    parameter int INFLIGHT_MAX    = 4,
    parameter int CNT_W           = 3,
    parameter int SCAN_CYCLES_MIN = 0,
    parameter int SCAN_CYCLES_MAX = 1000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             decode_valid,
    input  logic             decode_solo,
    input  logic             stall_decode,
    input  logic             flush_decode,
    input  logic             trap_hazard,
    input  logic             retire_valid,
    output logic             solo_drain_hold,
    output logic             solo_instr_hazard,
    output logic [CNT_W-1:0] inflight_count,
    input  logic             scan
);

    solo_state_e      state_q;
    solo_state_e      state_d;
    logic             issue;
    logic             cnt_zero;
    logic             last_retire;
    logic             overflow;
    logic [CNT_W-1:0] count;

    assign issue       = decode_valid & ~stall_decode & ~flush_decode;
    assign cnt_zero    = (count == '0);
    // The retire that empties the pipe; an overlapping issue would keep it non-empty.
    assign last_retire = retire_valid & ~issue & (count == CNT_W'(1));

    seven_stage_inflight_counter #(
        .CNT_W        (CNT_W),
        .INFLIGHT_MAX (INFLIGHT_MAX)
    ) u_inflight_counter (
        .clock    (clock),
        .reset    (reset),
        .inc      (issue),
        .dec      (retire_valid),
        .clr      (trap_hazard),
        .count    (count),
        .overflow (overflow)
    );

    always_comb begin
        state_d           = state_q;
        solo_drain_hold   = 1'b0;
        solo_instr_hazard = 1'b0;
        case (state_q)
            IDLE: begin
                solo_drain_hold = decode_valid & decode_solo & ~cnt_zero;
                if (decode_valid && decode_solo && !cnt_zero) begin
                    state_d = DRAIN;
                end else if (issue && decode_solo && cnt_zero) begin
                    state_d = SOLO;
                end
            end
            DRAIN: begin
                solo_drain_hold = ~cnt_zero;
                if (!decode_valid) begin
                    state_d = IDLE;
                end else if (issue && decode_solo && cnt_zero) begin
                    state_d = SOLO;
                end
            end
            SOLO: begin
                solo_instr_hazard = 1'b1;
                if (last_retire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (trap_hazard) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign inflight_count = count;

`ifndef SYNTHESIS
    int cycle_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_q <= 0;
        end else begin
            cycle_q <= cycle_q + 1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && scan && (cycle_q >= SCAN_CYCLES_MIN) && (cycle_q <= SCAN_CYCLES_MAX)) begin
            $display("[core%0d][cyc %0d] solo_seq: state=%s cnt=%0d hold=%0b hazard=%0b",
                     CORE, cycle_q, state_q.name(), count, solo_drain_hold, solo_instr_hazard);
        end
        if (!reset && overflow) begin
            $display("[core%0d][cyc %0d] solo_seq: error, issue with inflight count saturated at %0d",
                     CORE, cycle_q, count);
        end
    end
`endif

endmodule
